// File: rtl/mod14_count_checker_if.sv
// rtl/mod14_count_checker_if.sv - monitored signals of the mod-14 up/down counter
interface mod14_count_checker_if;
  logic       mon_reset;
  logic       mon_up_down;
  logic       mon_load;
  logic [3:0] mon_data_in;
  logic [3:0] mon_count;

  modport master (
    output mon_reset,
    output mon_up_down,
    output mon_load,
    output mon_data_in,
    output mon_count
  );

  modport slave (
    input mon_reset,
    input mon_up_down,
    input mon_load,
    input mon_data_in,
    input mon_count
  );
endinterface

// File: rtl/mod14_count_checker.sv
// rtl/mod14_count_checker.sv - cycle-accurate reference checker for the mod-14 up/down counter
module mod14_count_checker #(
  parameter int MODULUS = 14,
  parameter int ERR_W   = 8,
  parameter int CHK_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  mod14_count_checker_if.slave mon,
  output logic                 exp_valid,
  output logic [3:0]           expected,
  output logic                 mismatch,
  output logic                 load_range_err,
  output logic                 err_sticky,
  output logic [ERR_W-1:0]     err_count,
  output logic [CHK_W-1:0]     check_count,
  output logic [3:0]           first_err_exp,
  output logic [3:0]           first_err_act
);

  localparam logic [4:0] MOD_EXT = 5'(MODULUS);
  localparam logic [3:0] MAX_VAL = 4'(MODULUS - 1);

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         expected_q, expected_d;
  logic               mismatch_q, mismatch_d;
  logic               load_range_err_q, load_range_err_d;
  logic               err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [CHK_W-1:0]   check_count_q, check_count_d;
  logic [3:0]         first_err_exp_q, first_err_exp_d;
  logic [3:0]         first_err_act_q, first_err_act_d;

  logic [3:0]         ref_next;
  logic               load_illegal;
  logic               do_cmp;
  logic               cmp_fail;

  // Reference counter step, always from the model value, never from the DUT count.
  always_comb begin
    ref_next = expected_q;
    if (mon.mon_reset) begin
      ref_next = 4'd0;
    end else if (mon.mon_load) begin
      ref_next = mon.mon_data_in;
    end else if (mon.mon_up_down) begin
      ref_next = (expected_q == MAX_VAL) ? 4'd0 : expected_q + 4'd1;
    end else begin
      ref_next = (expected_q == 4'd0) ? MAX_VAL : expected_q - 4'd1;
    end
  end

  always_comb begin
    load_illegal = mon.mon_load && !mon.mon_reset && ({1'b0, mon.mon_data_in} >= MOD_EXT);
    do_cmp       = (state_q == ST_CHECK) && enable;
    // clear on the same edge drops the failure entirely
    cmp_fail     = do_cmp && (mon.mon_count != expected_q) && !clear;
  end

  always_comb begin
    state_d          = state_q;
    expected_d       = expected_q;
    mismatch_d       = cmp_fail;
    load_range_err_d = load_illegal;
    err_sticky_d     = err_sticky_q;
    err_count_d      = err_count_q;
    check_count_d    = check_count_q;
    first_err_exp_d  = first_err_exp_q;
    first_err_act_d  = first_err_act_q;

    case (state_q)
      ST_UNSYNC: begin
        if (mon.mon_reset) begin
          expected_d = 4'd0;
          state_d    = ST_CHECK;
        end else if (mon.mon_load && !load_illegal) begin
          expected_d = mon.mon_data_in;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (load_illegal) begin
          state_d = ST_UNSYNC;
        end else begin
          expected_d = ref_next;
        end
      end
      default: state_d = ST_UNSYNC;
    endcase

    if (clear) begin
      err_sticky_d    = 1'b0;
      err_count_d     = '0;
      check_count_d   = '0;
      first_err_exp_d = 4'd0;
      first_err_act_d = 4'd0;
    end else begin
      if (do_cmp && !(&check_count_q)) begin
        check_count_d = check_count_q + 1'b1;
      end
      if (cmp_fail) begin
        if (!(&err_count_q)) begin
          err_count_d = err_count_q + 1'b1;
        end
        if (err_count_q == '0) begin
          first_err_exp_d = expected_q;
          first_err_act_d = mon.mon_count;
        end
      end
      if (cmp_fail || load_illegal) begin
        err_sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_UNSYNC;
      expected_q       <= 4'd0;
      mismatch_q       <= 1'b0;
      load_range_err_q <= 1'b0;
      err_sticky_q     <= 1'b0;
      err_count_q      <= '0;
      check_count_q    <= '0;
      first_err_exp_q  <= 4'd0;
      first_err_act_q  <= 4'd0;
    end else begin
      state_q          <= state_d;
      expected_q       <= expected_d;
      mismatch_q       <= mismatch_d;
      load_range_err_q <= load_range_err_d;
      err_sticky_q     <= err_sticky_d;
      err_count_q      <= err_count_d;
      check_count_q    <= check_count_d;
      first_err_exp_q  <= first_err_exp_d;
      first_err_act_q  <= first_err_act_d;
    end
  end

  assign exp_valid      = (state_q == ST_CHECK);
  assign expected       = expected_q;
  assign mismatch       = mismatch_q;
  assign load_range_err = load_range_err_q;
  assign err_sticky     = err_sticky_q;
  assign err_count      = err_count_q;
  assign check_count    = check_count_q;
  assign first_err_exp  = first_err_exp_q;
  assign first_err_act  = first_err_act_q;

endmodule

// File: tb/tb_mod14_count_checker.sv
// tb/tb_mod14_count_checker.sv - directed bench for mod14_count_checker
module tb_mod14_count_checker;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic        exp_valid;
  logic [3:0]  expected;
  logic        mismatch;
  logic        load_range_err;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic [15:0] check_count;
  logic [3:0]  first_err_exp;
  logic [3:0]  first_err_act;

  logic [3:0]  dut_cnt = 4'd0;
  logic        force_en = 1'b0;
  logic [3:0]  force_val = 4'd0;

  int tests = 0;
  int fails = 0;

  mod14_count_checker_if mon_if ();

  mod14_count_checker #(.MODULUS(14), .ERR_W(8), .CHK_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .clear          (clear),
    .mon            (mon_if.slave),
    .exp_valid      (exp_valid),
    .expected       (expected),
    .mismatch       (mismatch),
    .load_range_err (load_range_err),
    .err_sticky     (err_sticky),
    .err_count      (err_count),
    .check_count    (check_count),
    .first_err_exp  (first_err_exp),
    .first_err_act  (first_err_act)
  );

  always #5 clock = ~clock;

  // Stand-in for a correct counter DUT; force_en overrides its visible output.
  always @(posedge clock) begin
    if (mon_if.mon_reset)        dut_cnt <= 4'd0;
    else if (mon_if.mon_load)    dut_cnt <= mon_if.mon_data_in;
    else if (mon_if.mon_up_down) dut_cnt <= (dut_cnt == 4'd13) ? 4'd0 : dut_cnt + 4'd1;
    else                         dut_cnt <= (dut_cnt == 4'd0) ? 4'd13 : dut_cnt - 4'd1;
  end

  assign mon_if.mon_count = force_en ? force_val : dut_cnt;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    mon_if.mon_reset   = 1'b0;
    mon_if.mon_up_down = 1'b1;
    mon_if.mon_load    = 1'b0;
    mon_if.mon_data_in = 4'd0;

    #22;
    check("rst_exp_valid", exp_valid, 0);
    check("rst_expected", expected, 0);
    check("rst_err_count", err_count, 0);
    check("rst_check_count", check_count, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_first_exp", first_err_exp, 0);
    step();
    reset = 1'b1;

    // Sync via mon_reset, then count up 20 edges.
    mon_if.mon_reset = 1'b1;
    step();
    mon_if.mon_reset = 1'b0;
    check("sync_exp_valid", exp_valid, 1);
    check("sync_expected", expected, 0);
    check("sync_no_cmp", check_count, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      check("up_expected", expected, i % 14);
      check("up_mismatch", mismatch, 0);
    end
    check("up_err_count", err_count, 0);
    check("up_check_count", check_count, 20);

    // Load 5 then count down across the zero boundary.
    mon_if.mon_load    = 1'b1;
    mon_if.mon_data_in = 4'd5;
    mon_if.mon_up_down = 1'b0;
    step();
    mon_if.mon_load = 1'b0;
    check("load5_expected", expected, 5);
    step(); check("dn_4", expected, 4);
    step(); check("dn_3", expected, 3);
    step(); check("dn_2", expected, 2);
    step(); check("dn_1", expected, 1);
    step(); check("dn_0", expected, 0);
    step(); check("dn_13", expected, 13);
    step(); check("dn_12", expected, 12);
    check("dn_err_count", err_count, 0);
    check("dn_check_count", check_count, 28);

    // Single-cycle mismatch: DUT shows 9 while 4 is expected.
    for (int i = 0; i < 8; i++) step();
    check("pre_mis_expected", expected, 4);
    force_en  = 1'b1;
    force_val = 4'd9;
    step();
    force_en = 1'b0;
    check("mis_pulse", mismatch, 1);
    check("mis_err_count", err_count, 1);
    check("mis_sticky", err_sticky, 1);
    check("mis_first_exp", first_err_exp, 4);
    check("mis_first_act", first_err_act, 9);
    check("mis_model_cont", expected, 3);
    step();
    check("mis_one_cycle", mismatch, 0);
    check("mis_model_cont2", expected, 2);
    check("mis_err_hold", err_count, 1);
    check("mis_check_count", check_count, 38);

    // Illegal load of 15 drops sync; legal load of 13 resyncs and wraps up.
    mon_if.mon_load    = 1'b1;
    mon_if.mon_data_in = 4'd15;
    step();
    mon_if.mon_load = 1'b0;
    check("ill_lre", load_range_err, 1);
    check("ill_exp_valid", exp_valid, 0);
    check("ill_check_count", check_count, 39);
    step();
    check("ill_lre_pulse", load_range_err, 0);
    check("ill_no_cmp", check_count, 39);
    mon_if.mon_up_down = 1'b1;
    mon_if.mon_load    = 1'b1;
    mon_if.mon_data_in = 4'd13;
    step();
    mon_if.mon_load = 1'b0;
    check("rs13_exp_valid", exp_valid, 1);
    check("rs13_expected", expected, 13);
    step();
    check("rs13_wrap", expected, 0);
    check("rs13_check_count", check_count, 40);
    step();
    check("rs13_next", expected, 1);
    check("rs13_mismatch", mismatch, 0);

    // mon_reset overrides a load on the same edge, legal or not.
    mon_if.mon_reset   = 1'b1;
    mon_if.mon_load    = 1'b1;
    mon_if.mon_data_in = 4'd7;
    step();
    check("rl7_expected", expected, 0);
    check("rl7_lre", load_range_err, 0);
    mon_if.mon_data_in = 4'd15;
    step();
    check("rl15_expected", expected, 0);
    check("rl15_lre", load_range_err, 0);
    check("rl15_exp_valid", exp_valid, 1);
    mon_if.mon_reset = 1'b0;
    mon_if.mon_load  = 1'b0;

    // Mismatch coincident with clear is dropped.
    clear     = 1'b1;
    force_en  = 1'b1;
    force_val = 4'd9;
    step();
    clear    = 1'b0;
    force_en = 1'b0;
    check("clr_mismatch", mismatch, 0);
    check("clr_err_count", err_count, 0);
    check("clr_sticky", err_sticky, 0);
    check("clr_check_count", check_count, 0);
    check("clr_first_act", first_err_act, 0);
    check("clr_model_runs", expected, 1);

    // 300 consecutive mismatches saturate err_count at 255.
    force_en  = 1'b1;
    force_val = 4'd15;
    for (int i = 0; i < 300; i++) step();
    check("sat_err_count", err_count, 255);
    check("sat_mismatch", mismatch, 1);
    check("sat_check_count", check_count, 300);
    check("sat_first_exp", first_err_exp, 1);
    check("sat_first_act", first_err_act, 15);

    // Async reset between edges clears everything immediately.
    #3;
    reset = 1'b0;
    #1;
    check("ar_exp_valid", exp_valid, 0);
    check("ar_err_count", err_count, 0);
    check("ar_check_count", check_count, 0);
    check("ar_sticky", err_sticky, 0);
    check("ar_mismatch", mismatch, 0);
    check("ar_first_act", first_err_act, 0);
    step();
    reset    = 1'b1;
    force_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar_unsync", exp_valid, 0);
    end
    mon_if.mon_reset = 1'b1;
    step();
    mon_if.mon_reset = 1'b0;
    check("ar_resync", exp_valid, 1);
    check("ar_resync_exp", expected, 0);

    // enable=0: no mismatch or counting, model still advances, range error still reported.
    enable    = 1'b0;
    force_en  = 1'b1;
    force_val = 4'd15;
    step();
    check("en0_mismatch", mismatch, 0);
    check("en0_err_count", err_count, 0);
    check("en0_check_count", check_count, 0);
    check("en0_expected", expected, 1);
    force_en           = 1'b0;
    mon_if.mon_load    = 1'b1;
    mon_if.mon_data_in = 4'd14;
    step();
    mon_if.mon_load = 1'b0;
    check("en0_lre", load_range_err, 1);
    check("en0_sticky", err_sticky, 1);
    check("en0_exp_valid", exp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
